// File: rtl/scaler_ctrl_if.sv
// Command, engine-stream and framebuffer signals of the scaler sequencer.
// Master drives commands and engine outputs; slave is the sequencer itself.
interface scaler_ctrl_if #(
    parameter int NUM_ENGINES = 4
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [2:0]                  cmd_op;
    logic                        cmd_abort;
    logic [NUM_ENGINES-1:0]      eng_rst_n;
    logic [NUM_ENGINES-1:0]      eng_done;
    logic [17*NUM_ENGINES-1:0]   eng_w_addr;
    logic [8*NUM_ENGINES-1:0]    eng_pixel;
    logic                        mem_we;
    logic [16:0]                 mem_w_addr;
    logic [7:0]                  mem_pixel;
    logic                        busy;
    logic                        done;
    logic                        error;
    logic [1:0]                  err_code;
    logic [2:0]                  active_op;
    logic [31:0]                 last_cycles;

    modport slave (
        input  cmd_valid, cmd_op, cmd_abort, eng_done, eng_w_addr, eng_pixel,
        output cmd_ready, eng_rst_n, mem_we, mem_w_addr, mem_pixel,
               busy, done, error, err_code, active_op, last_cycles
    );

    modport master (
        output cmd_valid, cmd_op, cmd_abort, eng_done, eng_w_addr, eng_pixel,
        input  cmd_ready, eng_rst_n, mem_we, mem_w_addr, mem_pixel,
               busy, done, error, err_code, active_op, last_cycles
    );
endinterface

// File: rtl/scaler_ctrl.sv
// Sequencer for scaling engines: reset-pulse selected engine, run it, mux its writes, report done/timeout/abort.
// Latency: accept at edge T, START cycle after T, engine released one edge later; NOP gives DONE the cycle after T.
// Backpressure: cmd_ready only in IDLE, commands while busy are dropped. SCALER_CTRL_PERF_EN adds a RUN-cycle counter.
module scaler_ctrl #(
    parameter int NUM_ENGINES    = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_W           = 17
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    scaler_ctrl_if.slave io_bus
);
    localparam int SEL_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_FIN} state_t;

    state_t                 r_state;
    logic [SEL_W-1:0]       r_sel;
    logic [TO_W-1:0]        r_wdog;
    logic [NUM_ENGINES-1:0] r_eng_rst_n;
    logic                   r_mem_we;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;
    logic [1:0]             r_err_code;
    logic [2:0]             r_active_op;

    logic                   w_op_legal;
    logic                   w_sel_done;
    logic [16:0]            w_addr;
    logic [7:0]             w_pixel;

    assign w_op_legal = (io_bus.cmd_op != 3'd0) && (int'(io_bus.cmd_op) <= NUM_ENGINES);
    assign w_sel_done = io_bus.eng_done[r_sel];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_wdog      <= '0;
            r_eng_rst_n <= '0;
            r_mem_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= 2'd0;
            r_active_op <= 3'd0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE && io_bus.cmd_abort) begin
                r_state     <= S_IDLE;
                r_eng_rst_n <= '0;
                r_mem_we    <= 1'b0;
                r_busy      <= 1'b0;
                r_error     <= 1'b1;
                r_err_code  <= 2'd3;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (io_bus.cmd_valid) begin
                            r_active_op <= io_bus.cmd_op;
                            r_error     <= 1'b0;
                            r_err_code  <= 2'd0;
                            if (io_bus.cmd_op == 3'd0) begin
                                r_state <= S_FIN;
                                r_busy  <= 1'b1;
                                r_done  <= 1'b1;
                            end else if (w_op_legal) begin
                                r_state <= S_START;
                                r_busy  <= 1'b1;
                                r_sel   <= SEL_W'(io_bus.cmd_op - 3'd1);
                            end else begin
                                r_error    <= 1'b1;
                                r_err_code <= 2'd1;
                            end
                        end
                    end
                    S_START: begin
                        r_state     <= S_RUN;
                        r_wdog      <= '0;
                        r_eng_rst_n <= NUM_ENGINES'(1) << r_sel;
                        r_mem_we    <= 1'b1;
                    end
                    S_RUN: begin
                        if (w_sel_done) begin
                            r_state     <= S_FIN;
                            r_done      <= 1'b1;
                            r_eng_rst_n <= '0;
                            r_mem_we    <= 1'b0;
                        end else if (r_wdog == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            r_state     <= S_IDLE;
                            r_eng_rst_n <= '0;
                            r_mem_we    <= 1'b0;
                            r_busy      <= 1'b0;
                            r_error     <= 1'b1;
                            r_err_code  <= 2'd2;
                        end else begin
                            r_wdog <= r_wdog + 1'b1;
                        end
                    end
                    S_FIN: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef SCALER_CTRL_PERF_EN
    logic [31:0] r_perf;
    logic [31:0] r_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf <= '0;
            r_last <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_perf <= '0;
                    if (io_bus.cmd_valid && io_bus.cmd_op == 3'd0)
                        r_last <= '0;
                end
                S_START: r_perf <= '0;
                S_RUN: begin
                    // The completing cycle itself is a RUN cycle, hence the +1 on load.
                    if (!io_bus.cmd_abort && w_sel_done)
                        r_last <= (r_perf == '1) ? '1 : r_perf + 32'd1;
                    else if (r_perf != '1)
                        r_perf <= r_perf + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.last_cycles = r_last;
`else
    assign io_bus.last_cycles = '0;
`endif

    always_comb begin
        w_addr  = '0;
        w_pixel = '0;
        if (r_state == S_RUN) begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (r_sel == SEL_W'(i)) begin
                    w_addr  = io_bus.eng_w_addr[17*i +: 17];
                    w_pixel = io_bus.eng_pixel[8*i +: 8];
                end
            end
        end
    end

    assign io_bus.cmd_ready  = (r_state == S_IDLE);
    assign io_bus.eng_rst_n  = r_eng_rst_n;
    assign io_bus.mem_we     = r_mem_we;
    assign io_bus.mem_w_addr = w_addr;
    assign io_bus.mem_pixel  = w_pixel;
    assign io_bus.busy       = r_busy;
    // An abort landing in FIN suppresses the already-registered completion pulse.
    assign io_bus.done       = r_done & ~io_bus.cmd_abort;
    assign io_bus.error      = r_error;
    assign io_bus.err_code   = r_err_code;
    assign io_bus.active_op  = r_active_op;
endmodule

// File: tb/tb_scaler_ctrl.sv
// Directed bench for scaler_ctrl: NOP, long frame, illegal op, abort, timeout (second instance) and async reset.
module tb_scaler_ctrl;
    localparam int NE        = 4;
    localparam int FRAME     = 76801;

    logic clk;
    logic rst_n;

    scaler_ctrl_if #(.NUM_ENGINES(NE)) bus  ();
    scaler_ctrl_if #(.NUM_ENGINES(NE)) bus2 ();

    scaler_ctrl #(.NUM_ENGINES(NE)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus.slave)
    );

    scaler_ctrl #(.NUM_ENGINES(NE), .TIMEOUT_CYCLES(100), .TO_W(17)) u_dut_to (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: counter cleared while held in reset; engine 0 finishes after FRAME run cycles.
    logic [16:0]   eng_cnt [NE];
    logic [NE-1:0] force_done;

    always @(posedge clk) begin
        for (int i = 0; i < NE; i++) begin
            if (!bus.eng_rst_n[i]) eng_cnt[i] <= '0;
            else                   eng_cnt[i] <= eng_cnt[i] + 17'd1;
        end
    end

    always_comb begin
        bus.eng_w_addr = '0;
        bus.eng_pixel  = '0;
        for (int i = 0; i < NE; i++) begin
            bus.eng_w_addr[17*i +: 17] = eng_cnt[i] + 17'(i * 4096);
            bus.eng_pixel[8*i +: 8]    = eng_cnt[i][7:0] ^ 8'(i * 17);
        end
    end

    assign bus.eng_done  = force_done |
                           {3'b000, (bus.eng_rst_n[0] && eng_cnt[0] == 17'(FRAME - 1))};
    assign bus2.eng_done   = '0;
    assign bus2.eng_w_addr = '0;
    assign bus2.eng_pixel  = '0;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    int we_cnt;
    int done_cnt;
    logic [31:0] exp_last;

    initial begin
        rst_n          = 1'b0;
        force_done     = '0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 3'd0;
        bus.cmd_abort  = 1'b0;
        bus2.cmd_valid = 1'b0;
        bus2.cmd_op    = 3'd0;
        bus2.cmd_abort = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_eng_rst_n", 32'(bus.eng_rst_n), 32'h0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'h0);
        chk("rst_busy",      32'(bus.busy),      32'h0);
        chk("rst_done",      32'(bus.done),      32'h0);
        chk("rst_error",     32'(bus.error),     32'h0);
        chk("rst_err_code",  32'(bus.err_code),  32'h0);
        chk("rst_active_op", 32'(bus.active_op), 32'h0);
        chk("rst_last",      bus.last_cycles,    32'h0);
        chk("rst_ready",     32'(bus.cmd_ready), 32'h1);
        rst_n = 1'b1;

        // NOP
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("nop_done",    32'(bus.done),      32'h1);
        chk("nop_busy",    32'(bus.busy),      32'h1);
        chk("nop_ready",   32'(bus.cmd_ready), 32'h0);
        chk("nop_eng",     32'(bus.eng_rst_n), 32'h0);
        chk("nop_we",      32'(bus.mem_we),    32'h0);
        @(negedge clk);
        chk("nop_done_end", 32'(bus.done),     32'h0);
        chk("nop_busy_end", 32'(bus.busy),     32'h0);

        // Illegal op, then NOP clears the error
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd6;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("ill_error",  32'(bus.error),     32'h1);
        chk("ill_code",   32'(bus.err_code),  32'h1);
        chk("ill_ready",  32'(bus.cmd_ready), 32'h1);
        chk("ill_eng",    32'(bus.eng_rst_n), 32'h0);
        chk("ill_op",     32'(bus.active_op), 32'h6);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("clr_error", 32'(bus.error),    32'h0);
        chk("clr_code",  32'(bus.err_code), 32'h0);
        chk("clr_done",  32'(bus.done),     32'h1);
        @(negedge clk);

        // Op 1: full frame on engine 0, stray done from other engines mid-run
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("op1_start_busy", 32'(bus.busy),      32'h1);
        chk("op1_start_eng",  32'(bus.eng_rst_n), 32'h0);
        chk("op1_start_we",   32'(bus.mem_we),    32'h0);
        we_cnt   = 0;
        done_cnt = 0;
        for (int c = 0; c < FRAME + 100; c++) begin
            @(negedge clk);
            force_done = (we_cnt == 99) ? 4'b1110 : 4'b0000;
            if (bus.done) begin
                done_cnt++;
                break;
            end
            if (bus.mem_we) begin
                we_cnt++;
                if (we_cnt == 1 || we_cnt == 5000 || we_cnt == FRAME) begin
                    chk("op1_addr",  32'(bus.mem_w_addr), 32'(we_cnt - 1));
                    chk("op1_eng",   32'(bus.eng_rst_n),  32'h1);
                end
                if (we_cnt == 5000)
                    chk("op1_pixel", 32'(bus.mem_pixel), 32'h87);
            end
        end
        force_done = '0;
        chk("op1_we_cycles", 32'(we_cnt),       32'(FRAME));
        chk("op1_done_seen", 32'(done_cnt),     32'h1);
        chk("op1_fin_we",    32'(bus.mem_we),   32'h0);
        chk("op1_fin_eng",   32'(bus.eng_rst_n), 32'h0);
`ifdef SCALER_CTRL_PERF_EN
        exp_last = 32'(FRAME);
`else
        exp_last = 32'h0;
`endif
        chk("op1_last", bus.last_cycles, exp_last);
        @(negedge clk);
        chk("op1_done_once", 32'(bus.done),     32'h0);
        chk("op1_idle_busy", 32'(bus.busy),     32'h0);
        chk("idle_addr_zero", 32'(bus.mem_w_addr), 32'h0);

        // Abort and done in the same RUN cycle on engine 1
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("ab_run_eng",  32'(bus.eng_rst_n),  32'h2);
        chk("ab_run_addr", 32'(bus.mem_w_addr), 32'd4096);
        force_done    = 4'b0010;
        bus.cmd_abort = 1'b1;
        @(negedge clk);
        force_done    = '0;
        bus.cmd_abort = 1'b0;
        chk("ab_done",  32'(bus.done),      32'h0);
        chk("ab_error", 32'(bus.error),     32'h1);
        chk("ab_code",  32'(bus.err_code),  32'h3);
        chk("ab_busy",  32'(bus.busy),      32'h0);
        chk("ab_eng",   32'(bus.eng_rst_n), 32'h0);
        chk("ab_we",    32'(bus.mem_we),    32'h0);
        @(negedge clk);
        chk("ab_no_late_done", 32'(bus.done), 32'h0);

        // Abort during FIN of a NOP suppresses DONE
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_abort = 1'b1;
        #1;
        chk("finab_done", 32'(bus.done), 32'h0);
        @(negedge clk);
        bus.cmd_abort = 1'b0;
        chk("finab_code", 32'(bus.err_code), 32'h3);
        chk("finab_busy", 32'(bus.busy),     32'h0);

        // Timeout on the short-watchdog instance, engine 2 never finishes
        bus2.cmd_valid = 1'b1;
        bus2.cmd_op    = 3'd3;
        @(negedge clk);
        bus2.cmd_valid = 1'b0;
        we_cnt   = 0;
        done_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus2.done) done_cnt++;
            if (!bus2.mem_we) break;
            we_cnt++;
            if (we_cnt == 1) chk("to_eng_run", 32'(bus2.eng_rst_n), 32'h4);
        end
        chk("to_we_cycles", 32'(we_cnt),         32'd100);
        chk("to_code",      32'(bus2.err_code),  32'h2);
        chk("to_error",     32'(bus2.error),     32'h1);
        chk("to_busy",      32'(bus2.busy),      32'h0);
        chk("to_eng",       32'(bus2.eng_rst_n), 32'h0);
        chk("to_no_done",   32'(done_cnt),       32'h0);

        // Asynchronous reset mid-RUN
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ar_pre_we", 32'(bus.mem_we), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_eng",   32'(bus.eng_rst_n), 32'h0);
        chk("ar_we",    32'(bus.mem_we),    32'h0);
        chk("ar_busy",  32'(bus.busy),      32'h0);
        chk("ar_ready", 32'(bus.cmd_ready), 32'h1);
        chk("ar_op",    32'(bus.active_op), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_rel_ready", 32'(bus.cmd_ready), 32'h1);

        // New op on engine 3 finishing after 3 RUN cycles
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd4;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("op4_eng",  32'(bus.eng_rst_n),  32'h8);
        chk("op4_addr", 32'(bus.mem_w_addr), 32'd12288);
        @(negedge clk);
        @(negedge clk);
        force_done = 4'b1000;
        @(negedge clk);
        force_done = '0;
        chk("op4_done", 32'(bus.done), 32'h1);
`ifdef SCALER_CTRL_PERF_EN
        exp_last = 32'd3;
`else
        exp_last = 32'h0;
`endif
        chk("op4_last", bus.last_cycles, exp_last);
        @(negedge clk);
        chk("op4_done_end", 32'(bus.done),      32'h0);
        chk("op4_ready",    32'(bus.cmd_ready), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
